dedisp_delay_scheduler: RTL and testbench
=========================================

Name: dedisp_delay_scheduler

Overview:
- Sequences a shared dedispersion delay memory for a time-multiplexed spectrum stream.
- Channels arrive serially, one sample per din_valid.
- Each channel owns a circular region of DEPTH slots in one external simple-dual-port BRAM (1-cycle read latency).
- The block holds a per-channel delay table loaded over a config port and generates the write/read addresses and write data for the BRAM. It also generates the output-valid qualification, so every channel is emitted delayed by its own number of spectra.

Parameters:
- N_CHAN, 64: channels per spectrum; power of two.
- DEPTH, 256: slots per channel region; power of two; maximum delay is DEPTH-1.
- DIN_WIDTH, 32: sample width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  pulse; IDLE->CLEAR.
- stop  in  1  pulse; request return to IDLE at the next spectrum boundary.
- cfg_we  in  1  delay-table write strobe.
- cfg_chan  in  log2(N_CHAN)  channel to configure.
- cfg_delay  in  log2(DEPTH)  delay in spectra.
- cfg_err  out  1  1-cycle pulse on a rejected or clamped config write.
- din  in  DIN_WIDTH  sample.
- din_valid  in  1  sample strobe.
- din_sync  in  1  qualifies din_valid; marks channel 0 of a spectrum.
- sync_err  out  1  1-cycle pulse on sync misalignment.
- mem_we  out  1  BRAM write enable.
- mem_waddr  out  log2(N_CHAN)+log2(DEPTH)  write address {chan, slot}.
- mem_wdata  out  DIN_WIDTH  write data.
- mem_re  out  1  BRAM read enable.
- mem_raddr  out  log2(N_CHAN)+log2(DEPTH)  read address {chan, slot}.
- dout_valid  out  1  BRAM read data is a valid delayed sample.
- dout_chan  out  log2(N_CHAN)  channel of the current BRAM read data.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, CLEAR, RUN, STOPPING. Reset: state=IDLE, chan_cnt=0, time_ptr=0, fill=0, all outputs 0.
- IDLE: din ignored, no memory traffic. Config writes accepted: table[cfg_chan] <= cfg_delay, effective next cycle.
  - A write with cfg_delay=0 stores 1 and pulses cfg_err on the following cycle.
  - start -> CLEAR.
- CLEAR: one cycle; zero chan_cnt, time_ptr, fill -> RUN.
- Config writes in any state other than IDLE are dropped and pulse cfg_err.
- Delay table is not cleared by rst. Power-up contents are all 1.
- RUN, per accepted sample (din_valid=1), cycle t:
  - Stage 1 (t+1): register din, chan=chan_cnt, d=table[chan].
  - Stage 2 (t+2): mem_we=mem_re=1; mem_waddr={chan, time_ptr}; mem_raddr={chan, (time_ptr-d) mod DEPTH}; mem_wdata=din.
  - Stage 3 (t+3): dout_valid=(fill>=d) captured at stage 2; dout_chan=chan.
  - Latency din->dout_valid is 3 cycles, fixed. Throughput is 1 sample/cycle; gaps are allowed.
- chan_cnt increments on each accepted sample and wraps N_CHAN-1 -> 0.
  - On the sample with chan_cnt=N_CHAN-1: time_ptr increments mod DEPTH, and fill increments, saturating at DEPTH.
  - time_ptr and fill update after stage 2 of that sample, so all channels of one spectrum use the same time_ptr.
- Read and write slots never coincide (d>=1), so the BRAM read-during-write mode is irrelevant.
- din_sync=1 with din_valid while chan_cnt!=0:
  - Sample is treated as channel 0; chan_cnt realigns to 1.
  - sync_err pulses at t+1.
  - time_ptr is not advanced for the truncated spectrum.
- din_sync while chan_cnt==0 is normal.
- stop in RUN:
  - If chan_cnt==0 and no sample is accepted that cycle -> IDLE.
  - Otherwise -> STOPPING. STOPPING processes samples until the N_CHAN-1 sample is accepted, then -> IDLE.
  - In-flight pipeline stages complete regardless of state.
- start in RUN/STOPPING, and stop in IDLE/CLEAR, are ignored.
- rst mid-operation clears the pipeline immediately: no mem_we, no dout_valid on the next cycle.
- busy=1 in CLEAR, RUN, STOPPING.

Test Plan:
- Config ch0=1, ch5=3, ch63=255; start; stream 300 spectra of din={spectrum_idx, chan} -> stage-3 BRAM output: ch0 first valid at spectrum 1 carrying spectrum 0; ch5 first valid at spectrum 3; ch63 first valid at spectrum 255 carrying spectrum 0. The 3-cycle latency holds with random din_valid gaps.
- Write cfg_delay=0 for ch7 in IDLE -> cfg_err pulse; table reads 1. Write during RUN -> cfg_err pulse; table unchanged.
- 260 spectra with DEPTH=256 -> time_ptr wraps 255->0; ch0 with delay 1 reads slot 255 while writing slot 0; fill saturates at 256; no dout_valid dropouts.
- din_sync asserted at chan_cnt=10 -> sync_err pulse at t+1; next samples addressed as ch1,2,...; time_ptr unchanged.
- stop at chan_cnt=20 -> busy stays 1 until ch63 is accepted, then IDLE; the last mem_we is for ch63; later din is ignored.
- rst asserted mid-spectrum in RUN -> next cycle mem_we=0, dout_valid=0, busy=0; table retains the configured delays.

Source files
------------

// File: rtl/dedisp_delay_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : dedisp_delay_scheduler_if
// Brief    : Sample stream in, delay-BRAM port and delayed-output qualifiers.
// Revision : 1.0 - initial release
// ============================================================================
interface dedisp_delay_scheduler_if #(
  parameter int N_CHAN    = 64,
  parameter int DEPTH     = 256,
  parameter int DIN_WIDTH = 32
);
  localparam int c_cw = $clog2(N_CHAN);
  localparam int c_aw = c_cw + $clog2(DEPTH);

  logic [DIN_WIDTH-1:0] din;
  logic                 din_valid;
  logic                 din_sync;
  logic                 mem_we;
  logic [c_aw-1:0]      mem_waddr;
  logic [DIN_WIDTH-1:0] mem_wdata;
  logic                 mem_re;
  logic [c_aw-1:0]      mem_raddr;
  logic                 dout_valid;
  logic [c_cw-1:0]      dout_chan;

  modport master (
    input  din, din_valid, din_sync,
    output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, dout_valid, dout_chan
  );

  modport slave (
    output din, din_valid, din_sync,
    input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, dout_valid, dout_chan
  );
endinterface
`default_nettype wire

// File: rtl/dedisp_delay_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dedisp_delay_scheduler
// Brief    : Address/valid sequencer for a shared per-channel dedispersion
//            delay BRAM with a loadable per-channel delay table.
// Revision : 1.0 - initial release
// ============================================================================
module dedisp_delay_scheduler #(
  parameter int N_CHAN    = 64,
  parameter int DEPTH     = 256,
  parameter int DIN_WIDTH = 32
) (
  input  wire                        clk,
  input  wire                        rst,
  input  wire                        start,
  input  wire                        stop,
  input  wire                        cfg_we,
  input  wire  [$clog2(N_CHAN)-1:0]  cfg_chan,
  input  wire  [$clog2(DEPTH)-1:0]   cfg_delay,
  output logic                       cfg_err,
  output logic                       sync_err,
  output logic                       busy,
  dedisp_delay_scheduler_if.master   bus
);
  localparam int c_cw = $clog2(N_CHAN);
  localparam int c_dw = $clog2(DEPTH);
  localparam logic [c_cw-1:0] c_last = c_cw'(N_CHAN - 1);
  localparam logic [c_dw:0]   c_full = (c_dw + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_cw-1:0]     r_chan_cnt;
  logic [c_dw-1:0]     r_time_ptr;
  logic [c_dw:0]       r_fill;
  // Entries hold delay-1, so an all-zero power-up state means delay 1.
  logic [c_dw-1:0]     r_table [N_CHAN];

  logic                r_s1_valid;
  logic                r_s1_last;
  logic [DIN_WIDTH-1:0] r_s1_din;
  logic [c_cw-1:0]     r_s1_chan;
  logic [c_dw-1:0]     r_s1_dm1;
  logic                r_s2_ok;
  logic [c_cw-1:0]     r_s2_chan;
  logic                r_cfg_err;
  logic                r_sync_err;

  logic                w_running;
  logic                w_accept;
  logic [c_cw-1:0]     w_chan;
  logic                w_last;
  logic [c_dw-1:0]     w_s1_delay;

  assign w_running  = (r_state == RUN) || (r_state == STOPPING);
  assign w_accept   = bus.din_valid && w_running;
  assign w_chan     = bus.din_sync ? '0 : r_chan_cnt;
  assign w_last     = (w_chan == c_last);
  assign w_s1_delay = r_s1_dm1 + 1'b1;

  assign cfg_err  = r_cfg_err;
  assign sync_err = r_sync_err;
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (cfg_we && (r_state == IDLE)) begin
      r_table[cfg_chan] <= (cfg_delay == '0) ? '0 : cfg_delay - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_chan_cnt     <= '0;
      r_time_ptr     <= '0;
      r_fill         <= '0;
      r_s1_valid     <= 1'b0;
      r_s1_last      <= 1'b0;
      r_s1_din       <= '0;
      r_s1_chan      <= '0;
      r_s1_dm1       <= '0;
      r_s2_ok        <= 1'b0;
      r_s2_chan      <= '0;
      r_cfg_err      <= 1'b0;
      r_sync_err     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_re     <= 1'b0;
      bus.mem_waddr  <= '0;
      bus.mem_raddr  <= '0;
      bus.mem_wdata  <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_chan  <= '0;
    end else begin
      r_cfg_err  <= cfg_we && ((r_state != IDLE) || (cfg_delay == '0));
      r_sync_err <= w_accept && bus.din_sync && (r_chan_cnt != '0);

      // Stage 1: capture sample and look up its delay.
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_din   <= bus.din;
        r_s1_chan  <= w_chan;
        r_s1_dm1   <= r_table[w_chan];
        r_s1_last  <= w_last;
        r_chan_cnt <= w_chan + 1'b1;
      end

      // Stage 2: drive the BRAM; time_ptr/fill advance at the same edge so
      // the next spectrum sees the new values.
      bus.mem_we <= r_s1_valid;
      bus.mem_re <= r_s1_valid;
      if (r_s1_valid) begin
        bus.mem_waddr <= {r_s1_chan, r_time_ptr};
        bus.mem_raddr <= {r_s1_chan, r_time_ptr - w_s1_delay};
        bus.mem_wdata <= r_s1_din;
        r_s2_ok       <= (r_fill >= {1'b0, w_s1_delay});
        r_s2_chan     <= r_s1_chan;
      end
      if (r_s1_valid && r_s1_last) begin
        r_time_ptr <= r_time_ptr + 1'b1;
        if (r_fill != c_full) begin
          r_fill <= r_fill + 1'b1;
        end
      end

      // Stage 3: qualify the BRAM read data.
      bus.dout_valid <= bus.mem_re && r_s2_ok;
      bus.dout_chan  <= r_s2_chan;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_chan_cnt <= '0;
          r_time_ptr <= '0;
          r_fill     <= '0;
          r_state    <= RUN;
        end
        RUN: begin
          if (stop) begin
            if ((r_chan_cnt == '0) && !w_accept) begin
              r_state <= IDLE;
            end else if (w_accept && w_last) begin
              r_state <= IDLE;
            end else begin
              r_state <= STOPPING;
            end
          end
        end
        STOPPING: begin
          if (w_accept && w_last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dedisp_delay_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dedisp_delay_scheduler
// Brief    : Directed self-checking bench with BRAM model and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dedisp_delay_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       cfg_we;
  logic [5:0] cfg_chan;
  logic [7:0] cfg_delay;
  logic       cfg_err;
  logic       sync_err;
  logic       busy;

  dedisp_delay_scheduler_if #(.N_CHAN(64), .DEPTH(256), .DIN_WIDTH(32)) bus ();

  dedisp_delay_scheduler #(.N_CHAN(64), .DEPTH(256), .DIN_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cfg_we    (cfg_we),
    .cfg_chan  (cfg_chan),
    .cfg_delay (cfg_delay),
    .cfg_err   (cfg_err),
    .sync_err  (sync_err),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Simple-dual-port BRAM, 1-cycle read latency.
  logic [31:0] bram [64*256];
  logic [31:0] rdata;
  always @(posedge clk) begin
    if (bus.mem_we) bram[bus.mem_waddr] <= bus.mem_wdata;
    if (bus.mem_re) rdata <= bram[bus.mem_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { int cyc; int ch; int ws; int rs; logic [31:0] wd; } s2_t;
  typedef struct { int cyc; logic v; int ch; logic [31:0] rd; } s3_t;
  s2_t q2[$];
  s3_t q3[$];

  int          dly [64];
  logic [31:0] shadow [64*256];
  int          m_chan;
  int          m_sp;
  logic        mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (q2.size() > 0 && q2[0].cyc == cyc) begin
        s2_t e;
        e = q2.pop_front();
        check("mem_we", bus.mem_we, 1'b1);
        check("mem_re", bus.mem_re, 1'b1);
        check("mem_waddr", bus.mem_waddr, 64'((e.ch << 8) | e.ws));
        check("mem_raddr", bus.mem_raddr, 64'((e.ch << 8) | e.rs));
        check("mem_wdata", bus.mem_wdata, e.wd);
      end else begin
        check("mem_we_idle", bus.mem_we, 1'b0);
      end
      if (q3.size() > 0 && q3[0].cyc == cyc) begin
        s3_t e;
        e = q3.pop_front();
        check("dout_valid", bus.dout_valid, e.v);
        check("dout_chan", bus.dout_chan, 64'(e.ch));
        if (e.v) check("dout_data", rdata, e.rd);
      end else begin
        check("dout_valid_idle", bus.dout_valid, 1'b0);
      end
    end
  end

  function automatic logic [31:0] din_of(input int s, input int c);
    return 32'((s << 8) | c);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // acc: whether the DUT is expected to accept this sample.
  task automatic drive(input logic [31:0] d, input logic sync, input logic stp, input logic acc);
    int   ch, dl, f, ws, rs;
    logic exp_serr;
    bus.din       = d;
    bus.din_valid = 1'b1;
    bus.din_sync  = sync;
    stop          = stp;
    exp_serr      = 1'b0;
    if (acc) begin
      ch       = sync ? 0 : m_chan;
      exp_serr = sync && (m_chan != 0);
      dl       = dly[ch];
      f        = (m_sp > 256) ? 256 : m_sp;
      ws       = m_sp % 256;
      rs       = (m_sp - dl + 256) % 256;
      q2.push_back('{cyc + 2, ch, ws, rs, d});
      q3.push_back('{cyc + 3, (f >= dl), ch, shadow[ch*256 + rs]});
      shadow[ch*256 + ws] = d;
      m_chan = (ch + 1) % 64;
      if (ch == 63) m_sp++;
    end
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.din_sync  = 1'b0;
    stop          = 1'b0;
    if (acc) check("sync_err", sync_err, exp_serr);
  endtask

  task automatic cfg_write(input int ch, input int d, input logic in_idle);
    cfg_we    = 1'b1;
    cfg_chan  = 6'(ch);
    cfg_delay = 8'(d);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check("cfg_err", cfg_err, !in_idle || (d == 0));
    if (in_idle) dly[ch] = (d == 0) ? 1 : d;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    m_chan = 0;
    m_sp   = 0;
    check("start_busy", busy, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required self-termination");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    cfg_chan = '0; cfg_delay = '0;
    bus.din = '0; bus.din_valid = 1'b0; bus.din_sync = 1'b0;
    m_chan = 0; m_sp = 0;
    for (int i = 0; i < 64; i++) dly[i] = 1;
    for (int i = 0; i < 64*256; i++) shadow[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_sync_err", sync_err, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_re", bus.mem_re, 1'b0);
    check("rst_dout_valid", bus.dout_valid, 1'b0);

    // Delay table setup; ch7 written non-zero then zero to prove the clamp.
    cfg_write(0, 1, 1'b1);
    cfg_write(5, 3, 1'b1);
    cfg_write(63, 255, 1'b1);
    cfg_write(7, 6, 1'b1);
    cfg_write(7, 0, 1'b1);
    cfg_write(10, 2, 1'b1);
    idle(1);
    check("idle_busy", busy, 1'b0);

    // Writes in CLEAR and RUN are dropped.
    do_start();
    cfg_write(5, 9, 1'b0);
    check("run_busy", busy, 1'b1);
    cfg_write(63, 4, 1'b0);

    // Main stream through the time_ptr wrap and fill saturation.
    for (int s = 0; s < 300; s++) begin
      for (int c = 0; c < 64; c++) begin
        drive(din_of(s, c), 1'b0, 1'b0, 1'b1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end

    // Sync realignment at chan_cnt 10.
    for (int c = 0; c < 10; c++) drive(din_of(m_sp, c) | 32'h4000_0000, 1'b0, 1'b0, 1'b1);
    drive(din_of(m_sp, 0) | 32'h5000_0000, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c < 64; c++) drive(din_of(m_sp, c) | 32'h5000_0000, 1'b0, 1'b0, 1'b1);

    // Stop mid-spectrum runs out to ch63, then input is ignored.
    for (int c = 0; c < 20; c++) drive(din_of(m_sp, c), 1'b0, 1'b0, 1'b1);
    drive(din_of(m_sp, 20), 1'b0, 1'b1, 1'b1);
    check("stop_busy", busy, 1'b1);
    for (int c = 21; c < 64; c++) begin
      drive(din_of(m_sp, c), 1'b0, 1'b0, 1'b1);
      check("stop_busy", busy, c != 63);
    end
    for (int k = 0; k < 3; k++) drive(din_of(999, k), 1'b0, 1'b0, 1'b0);
    check("stopped_busy", busy, 1'b0);
    idle(4);

    // Reset mid-spectrum clears the pipeline.
    do_start();
    idle(1);
    for (int k = 0; k < 158; k++) drive(din_of(m_sp, m_chan) | 32'h6000_0000, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    while (q2.size() > 0 && q2[q2.size()-1].cyc > cyc) q2.delete(q2.size() - 1);
    while (q3.size() > 0 && q3[q3.size()-1].cyc > cyc) q3.delete(q3.size() - 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_mem_we", bus.mem_we, 1'b0);
    check("midrst_dout_valid", bus.dout_valid, 1'b0);
    idle(3);

    // Delays survive reset; stop at a spectrum boundary goes straight to IDLE.
    do_start();
    idle(1);
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 64; c++) drive(din_of(s, c) | 32'h7000_0000, 1'b0, 1'b0, 1'b1);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    check("boundary_stop_busy", busy, 1'b0);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
